// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu definitions: fetch FSM states, PC step, buffer entry width
package cpu_pkg;

    // Fetch control: RUN while no stale responses are pending, FLUSH while they drain.
    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_e;

    localparam logic [31:0] PC_INC        = 32'd4;
    localparam int unsigned FETCH_ENTRY_W = 64;     // {pc, instruction}

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer FIFO with flush and write-while-full-and-read
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   flush               empties the FIFO (wins over write/read)
//   wr_valid, wr_data   push an entry at the tail
//   rd_ready            pop the head entry (ignored when empty)
//   rd_valid, rd_data   head entry
//   count               number of stored entries
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         wr_valid,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_en;
    logic             wr_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_en = rd_ready && (count_q != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle;
    // the head is read from mem_q before the edge overwrites that slot.
    assign wr_en = wr_valid && ((count_q != CW'(DEPTH)) || rd_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (rd_en) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; count_q alone qualifies it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC sequencing, memory requests, redirect flush, buffer
// Ports:
//   clk, reset_n                          clock, synchronous active-low reset
//   redirect_n, redirect_pc               active-low fetch restart at redirect_pc
//   imem_req_valid/addr/ready             request channel to instruction memory
//   imem_resp_valid/data                  in-order response channel
//   inst_valid/data/pc, inst_ready        buffered instruction stream to decode
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_n,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    // Discards can pile up across back-to-back redirects, so this counter gets headroom.
    localparam int unsigned DW = CW + 4;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;   // live requests whose responses will be kept
    logic [DW-1:0] discard_q, discard_d;           // stale responses still to be dropped

    logic [CW-1:0] buf_count;
    logic          buf_valid;
    logic [FETCH_ENTRY_W-1:0] buf_rd_data;

    logic [CW:0]   credit;
    logic          req_fire;
    logic          in_flush;
    logic          resp_fire;
    logic          resp_drop;
    logic          resp_live;
    logic [CW-1:0] out_after;
    logic [31:0]   resp_pc;

    assign credit         = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign imem_req_valid = reset_n && redirect_n && (credit < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing in flight are protocol violations and are ignored.
    assign in_flush  = (state_q == FETCH_FLUSH);
    assign resp_fire = imem_resp_valid && (in_flush || (outstanding_q != '0));
    assign resp_drop = resp_fire && in_flush;
    assign resp_live = resp_fire && !in_flush;

    assign out_after = outstanding_q + CW'(req_fire) - CW'(resp_live);

    // Live requests are consecutive words ending just below fetch_pc, so the
    // oldest one (the one this response answers) is fetch_pc - 4*outstanding.
    assign resp_pc = fetch_pc_q - 32'({outstanding_q, 2'b00});

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = out_after;
        discard_d     = discard_q - DW'(resp_drop);
        if (!redirect_n) begin
            // Every live request, including one answered this cycle, becomes stale.
            fetch_pc_d    = align_pc(redirect_pc);
            discard_d     = discard_d + DW'(out_after);
            outstanding_d = '0;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
        end
        state_d = (discard_d != '0) ? FETCH_FLUSH : FETCH_RUN;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= FETCH_RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (!redirect_n),
        .wr_valid (resp_live && redirect_n),
        .wr_data  ({resp_pc, imem_resp_data}),
        .rd_ready (inst_ready),
        .rd_valid (buf_valid),
        .rd_data  (buf_rd_data),
        .count    (buf_count)
    );

    assign inst_valid = reset_n && buf_valid;
    assign inst_pc    = buf_rd_data[63:32];
    assign inst_data  = buf_rd_data[31:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; also the maximum number of outstanding memory requests.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 redirect_n  in  1  active-low; when 0, the fetch stream restarts at redirect_pc (branch/jump taken).
REQ-006 redirect_pc  in  32  new program counter from the branch unit.
REQ-007 imem_req_valid  out  1  fetch request present.
REQ-008 imem_req_addr  out  32  word address of the fetch request.
REQ-009 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-010 imem_resp_valid  in  1  response word present; responses return in request order, with latency of at least 1 cycle.
REQ-011 imem_resp_data  in  32  instruction word.
REQ-012 inst_valid  out  1  buffered instruction available to decode.
REQ-013 inst_data  out  32  instruction at the buffer head.
REQ-014 inst_pc  out  32  program counter of inst_data.
REQ-015 inst_ready  in  1  decode consumes the head entry this cycle.

Function
REQ-016 Request transfer SHALL occur when imem_req_valid and imem_req_ready are both 1 on a rising edge; the output transfer SHALL occur when inst_valid and inst_ready are both 1.
REQ-017 fetch_pc SHALL advance by 4 (modulo 2^32, wrapping FFFF_FFFC -> 0000_0000) on each request transfer.
REQ-018 imem_req_valid SHALL be 1 only when (outstanding + buffered) < BUF_DEPTH and redirect_n is 1; imem_req_addr SHALL equal fetch_pc.
REQ-019 imem_req_valid and imem_req_addr SHALL remain stable until the request transfers, unless a redirect occurs.
REQ-020 Each accepted response not marked for discard SHALL be written to the buffer tail, tagged with its request address.
REQ-021 The buffer SHALL be a FIFO; inst_data/inst_pc SHALL come from the head; inst_valid = (buffered != 0).
REQ-022 Minimum latency: an instruction whose response arrives in cycle N SHALL be presented with inst_valid=1 in cycle N+1.
REQ-023 A simultaneous buffer write and read SHALL be permitted at any occupancy, including full, with no loss.
REQ-024 When redirect_n=0 on an edge: fetch_pc <= {redirect_pc[31:2],2'b00}; the buffer is emptied; all in-flight requests, including one transferring in the same cycle, are counted into discard_cnt; no request is issued in that cycle.
REQ-025 While discard_cnt > 0, each response SHALL decrement discard_cnt and SHALL NOT be written to the buffer.
REQ-026 A redirect arriving while discard_cnt > 0 SHALL add the current outstanding count to the pending discards; no stale word SHALL ever reach inst_valid.
REQ-027 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-028 A response with no request outstanding is a protocol violation; the design SHALL ignore it. Its behaviour is not specified.
REQ-029 Control SHALL be a 2-state FSM: RUN (normal operation) and FLUSH (discard_cnt != 0). New requests SHALL be allowed in FLUSH. FLUSH -> RUN when the last discard is consumed.

Reset
REQ-030 While reset_n=0 at an edge: fetch_pc <= RESET_PC; outstanding, discard_cnt and buffer count <= 0; FSM <= RUN.
REQ-031 During and immediately after reset: imem_req_valid=0 and inst_valid=0. The first request SHALL issue in the first cycle with reset_n=1.
REQ-032 A reset asserted mid-operation SHALL abandon in-flight requests. The external memory SHALL be reset at the same time.

Structure
REQ-033 The FSM state enum and the PC increment constant (4) SHALL live in the shared cpu package.
REQ-034 The buffer SHALL be a separate sub-module, fetch_fifo, parameterised by depth and width (64: pc+data).

Verification
REQ-035 Reset release, memory always ready, 1-cycle latency, inst_ready=1 -> requests at 0x0,0x4,0x8,... back-to-back; inst_pc follows the same sequence; inst_data matches memory contents.
REQ-036 inst_ready=0 for 6 cycles -> at most 2 requests issued; buffer holds 0x0 and 0x4; imem_req_valid=0; after inst_ready=1, no instruction is lost or duplicated.
REQ-037 redirect_n=0 with redirect_pc=0x0000_0102 while 2 requests are outstanding -> next request address is 0x0000_0100; the 2 stale responses are dropped; the first inst_pc is 0x100.
REQ-038 Two redirects 1 cycle apart (to 0x40, then 0x80) with 3-cycle memory latency -> only instructions from 0x80 onward appear.
REQ-039 RESET_PC=0xFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
REQ-040 reset_n=0 for 1 cycle mid-stream -> inst_valid=0 next cycle; fetching restarts at RESET_PC.
